cpu_fetch_unit: RTL and testbench
=================================

# cpu_fetch_unit

Program counter, memory-address register and instruction register for the 8-bit CPU; sits directly upstream of `cpu_control`, supplying its `opcode` input and acting on the `state` it produces. Each rising `clk` edge it samples the current `state` code and performs that state's fetch-side action: PC increment, instruction latch, operand/address latch, conditional jump, or halt. It drives the memory address for every fetch and load, and pulses a done strobe when an instruction retires.

## Interface
- `PC_WIDTH`, 8: program counter / address width.
- `RESET_VECTOR`, 8'h00: PC value after reset.
- `clk` in 1: system clock, all state changes on rising edge.
- `reset_cycle` in 1: reset reset_cycle, asynchronous, active-high; clock clk.
- `state` in 4: current state code from `cpu_control` (`STATE_*` encoding).
- `bus_in` in 8: memory/bus read data.
- `zero_flag` in 1: ALU zero flag, sampled only in `STATE_JUMP`.
- `opcode` out 8: instruction register contents, to `cpu_control`.
- `operand` out 8: last latched operand byte.
- `pc` out PC_WIDTH: program counter.
- `mem_addr` out PC_WIDTH: memory address register (MAR) contents.
- `halted` out 1: sticky halt indicator.
- `instr_done` out 1: one-cycle pulse on instruction retire.

## Operation
- Reset values: `pc`=RESET_VECTOR, `mem_addr`=0, `opcode`=0, `operand`=0, `halted`=0, `instr_done`=0.
- Per edge, action selected by sampled `state`:
  - `STATE_FETCH_PC`: MAR ← pc; pc ← pc+1 (mod 2^PC_WIDTH, 0xFF→0x00).
  - `STATE_FETCH_INST`: opcode ← bus_in.
  - `STATE_LOAD_ADDR`: operand ← bus_in; MAR ← bus_in.
  - `STATE_LDI`: operand ← bus_in.
  - `STATE_JUMP`: operand ← bus_in; pc ← bus_in if opcode is `OP_JMP`, or `OP_JEZ` with zero_flag=1, or `OP_JNZ` with zero_flag=0; otherwise pc unchanged.
  - `STATE_HALT`: halted ← 1.
  - `STATE_NEXT`: instr_done ← 1 for exactly one cycle.
  - All other states (`STATE_OUT_A`, `STATE_RAM_A/B`, `STATE_STORE_A`, `STATE_ALU_OP`, `STATE_MOV_*`): hold all registers.
- `instr_done` is 0 in every cycle not following a sampled `STATE_NEXT`.
- Opcode matching uses the same casez patterns as the rest of the CPU (`OP_*` constants, don't-care fields honoured).
- Once `halted`=1: pc, MAR, opcode, operand frozen; all state codes ignored; cleared only by `reset_cycle`.
- Unknown/undefined state code: hold, no error output.

## Timing
- Single-cycle latency: action for state S is visible on outputs the cycle after S is sampled.
- `STATE_FETCH_PC` then `STATE_FETCH_INST`: memory has one full cycle from MAR update to `bus_in` sampling; `bus_in` must be valid combinationally from `mem_addr` within that cycle.
- Operand fetch reuses `STATE_FETCH_PC`; second pc increment occurs there, so a non-jump two-byte instruction leaves pc = start+2.
- `reset_cycle` asserted mid-instruction: all outputs return to reset values immediately, independent of `clk`; first edge after deassertion acts on sampled `state` normally.
- Simultaneous reset and `STATE_HALT`: reset wins, `halted`=0.

## Configuration
- `CPU_FETCH_RETIRE_COUNT_EN`: when defined, adds output `retired` (16 bits), reset 0, incremented on each `STATE_NEXT` while not halted, wraps 0xFFFF→0. When undefined, the port and counter are absent; all other behaviour identical.

## Structure
- `STATE_*` and `OP_*` codes come from the shared CPU parameters include; no local redefinition.
- Jump-condition evaluation (opcode, zero_flag → take_jump) as combinational sub-module `cpu_jump_cond`; everything else in `cpu_fetch_unit`.

## Test plan
- Reset: assert `reset_cycle` with RESET_VECTOR=8'h00 → pc=0, opcode=0, halted=0; deassert, FETCH_PC → mem_addr=0, pc=1.
- Instruction latch: pc=5, FETCH_PC then FETCH_INST with bus_in=8'h3C → mem_addr=5, pc=6, opcode=8'h3C.
- Conditional jumps: opcode=`OP_JEZ`, bus_in=8'h40, zero_flag=1 in STATE_JUMP → pc=8'h40; repeat zero_flag=0 → pc unchanged; `OP_JNZ` zero_flag=0 → pc=8'h40.
- Wrap: pc=8'hFF, FETCH_PC → mem_addr=8'hFF, pc=8'h00.
- Halt: STATE_HALT → halted=1; subsequent FETCH_PC/JUMP leave pc and opcode unchanged; reset clears halted.
- Retire/macro: three STATE_NEXT cycles → three single-cycle `instr_done` pulses; with `CPU_FETCH_RETIRE_COUNT_EN` `retired`=3, reset mid-run → 0.

Source files
------------

// File: rtl/cpu_fetch_unit_pkg.sv
// Shared CPU codes and widths for the fetch unit: control-state encoding and jump opcodes.
// Optional feature macro: CPU_FETCH_RETIRE_COUNT_EN (adds the retired-instruction counter).
package cpu_fetch_unit_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned RETIRE_W = 16;

  typedef enum logic [STATE_W-1:0] {
    STATE_FETCH_PC   = 4'd0,
    STATE_FETCH_INST = 4'd1,
    STATE_LOAD_ADDR  = 4'd2,
    STATE_RAM_A      = 4'd3,
    STATE_RAM_B      = 4'd4,
    STATE_STORE_A    = 4'd5,
    STATE_LDI        = 4'd6,
    STATE_ALU_OP     = 4'd7,
    STATE_OUT_A      = 4'd8,
    STATE_JUMP       = 4'd9,
    STATE_MOV_FETCH  = 4'd10,
    STATE_MOV_LOAD   = 4'd11,
    STATE_MOV_STORE  = 4'd12,
    STATE_HALT       = 4'd13,
    STATE_NEXT       = 4'd14
  } cpu_state_e;

  // Jump family; the low two bits are don't-care in every casez match.
  localparam logic [DATA_W-1:0] OP_JMP = 8'b0010_00??;
  localparam logic [DATA_W-1:0] OP_JEZ = 8'b0010_01??;
  localparam logic [DATA_W-1:0] OP_JNZ = 8'b0010_10??;

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// Fetch-unit bus: control state and memory data in, PC/MAR/IR and status out.
// Optional feature macro: CPU_FETCH_RETIRE_COUNT_EN (adds the retired field).
interface cpu_fetch_unit_if
  import cpu_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 8
) ();

  logic [STATE_W-1:0]  state;
  logic [DATA_W-1:0]   bus_in;
  logic                zero_flag;
  logic [DATA_W-1:0]   opcode;
  logic [DATA_W-1:0]   operand;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] mem_addr;
  logic                halted;
  logic                instr_done;
`ifdef CPU_FETCH_RETIRE_COUNT_EN
  logic [RETIRE_W-1:0] retired;
`endif

  modport master (
    output state, bus_in, zero_flag,
    input  opcode, operand, pc, mem_addr, halted, instr_done
`ifdef CPU_FETCH_RETIRE_COUNT_EN
    , input retired
`endif
  );

  modport slave (
    input  state, bus_in, zero_flag,
    output opcode, operand, pc, mem_addr, halted, instr_done
`ifdef CPU_FETCH_RETIRE_COUNT_EN
    , output retired
`endif
  );

endinterface

// File: rtl/cpu_jump_cond.sv
// Combinational jump decision from the latched opcode and the ALU zero flag.
module cpu_jump_cond
  import cpu_fetch_unit_pkg::*;
(
  input  logic [DATA_W-1:0] opcode,
  input  logic              zero_flag,
  output logic              take_jump_c
);

  always_comb begin
    take_jump_c = 1'b0;
    casez (opcode)
      OP_JMP:  take_jump_c = 1'b1;
      OP_JEZ:  take_jump_c = zero_flag;
      OP_JNZ:  take_jump_c = ~zero_flag;
      default: take_jump_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_fetch_unit.sv
// CPU fetch unit: PC, MAR, instruction and operand registers driven by the control state code.
// Optional feature macro: CPU_FETCH_RETIRE_COUNT_EN (16-bit retired-instruction counter).
module cpu_fetch_unit
  import cpu_fetch_unit_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic           clk,
  input  logic           reset_cycle,
  cpu_fetch_unit_if.slave bus
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_W-1:0]   opcode_q, opcode_d;
  logic [DATA_W-1:0]   operand_q, operand_d;
  logic                halted_q, halted_d;
  logic                done_q, done_d;
  logic                take_jump_c;

  cpu_jump_cond u_jump_cond (
    .opcode      (opcode_q),
    .zero_flag   (bus.zero_flag),
    .take_jump_c (take_jump_c)
  );

  // Per-state register updates; a halted unit ignores every state code.
  always_comb begin
    pc_d      = pc_q;
    mar_d     = mar_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    halted_d  = halted_q;
    done_d    = 1'b0;
    if (!halted_q) begin
      case (bus.state)
        STATE_FETCH_PC: begin
          mar_d = pc_q;
          pc_d  = pc_q + PC_WIDTH'(1);
        end
        STATE_FETCH_INST: opcode_d = bus.bus_in;
        STATE_LOAD_ADDR: begin
          operand_d = bus.bus_in;
          mar_d     = PC_WIDTH'(bus.bus_in);
        end
        STATE_LDI: operand_d = bus.bus_in;
        STATE_JUMP: begin
          operand_d = bus.bus_in;
          if (take_jump_c) pc_d = PC_WIDTH'(bus.bus_in);
        end
        STATE_HALT: halted_d = 1'b1;
        STATE_NEXT: done_d   = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      pc_q      <= RESET_VECTOR;
      mar_q     <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      halted_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      halted_q  <= halted_d;
      done_q    <= done_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.mem_addr   = mar_q;
  assign bus.opcode     = opcode_q;
  assign bus.operand    = operand_q;
  assign bus.halted     = halted_q;
  assign bus.instr_done = done_q;

`ifdef CPU_FETCH_RETIRE_COUNT_EN
  logic [RETIRE_W-1:0] retired_q, retired_d;

  // Counts retirements; wraps naturally at the counter width.
  always_comb begin
    retired_d = retired_q;
    if (!halted_q && (bus.state == STATE_NEXT)) retired_d = retired_q + RETIRE_W'(1);
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) retired_q <= '0;
    else             retired_q <= retired_d;
  end

  assign bus.retired = retired_q;
`endif

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit: per-cycle compare against a behavioural model plus literal checks.
// Optional feature macro: CPU_FETCH_RETIRE_COUNT_EN (also checks the retired counter).
module tb_cpu_fetch_unit;
  import cpu_fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic reset_cycle;

  cpu_fetch_unit_if #(.PC_WIDTH(8)) bus ();

  cpu_fetch_unit #(.PC_WIDTH(8), .RESET_VECTOR(8'h00)) dut (
    .clk         (clk),
    .reset_cycle (reset_cycle),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  // Model state, in plain integers
  int m_pc, m_mar, m_op, m_opnd, m_ret;
  bit m_halt, m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_take(input int op, input bit zf);
    int fam;
    fam = (op / 4) % 64;
    if (fam == 8)  return 1'b1;   // 0010_00xx
    if (fam == 9)  return zf;     // 0010_01xx
    if (fam == 10) return !zf;    // 0010_10xx
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_op = 0; m_opnd = 0; m_ret = 0;
    m_halt = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge(input int st, input int din, input bit zf);
    if (reset_cycle) begin
      model_reset();
      return;
    end
    m_done = 1'b0;
    if (m_halt) return;
    if (st == int'(STATE_FETCH_PC)) begin
      m_mar = m_pc;
      m_pc  = (m_pc + 1) % 256;
    end else if (st == int'(STATE_FETCH_INST)) begin
      m_op = din;
    end else if (st == int'(STATE_LOAD_ADDR)) begin
      m_opnd = din;
      m_mar  = din;
    end else if (st == int'(STATE_LDI)) begin
      m_opnd = din;
    end else if (st == int'(STATE_JUMP)) begin
      m_opnd = din;
      if (model_take(m_op, zf)) m_pc = din;
    end else if (st == int'(STATE_HALT)) begin
      m_halt = 1'b1;
    end else if (st == int'(STATE_NEXT)) begin
      m_done = 1'b1;
      m_ret  = (m_ret + 1) % 65536;
    end
  endtask

  task automatic step(input logic [3:0] st, input logic [7:0] din, input logic zf);
    bus.state     = st;
    bus.bus_in    = din;
    bus.zero_flag = zf;
    @(posedge clk);
    model_edge(int'(st), int'(din), zf);
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("pc",         32'(bus.pc),         32'(m_pc));
    check("mem_addr",   32'(bus.mem_addr),   32'(m_mar));
    check("opcode",     32'(bus.opcode),     32'(m_op));
    check("operand",    32'(bus.operand),    32'(m_opnd));
    check("halted",     32'(bus.halted),     32'(m_halt));
    check("instr_done", 32'(bus.instr_done), 32'(m_done));
`ifdef CPU_FETCH_RETIRE_COUNT_EN
    check("retired",    32'(bus.retired),    32'(m_ret));
`endif
    if (bus.instr_done === 1'b1) pulses++;
  end

  initial begin
    bus.state     = STATE_FETCH_PC;
    bus.bus_in    = 8'h00;
    bus.zero_flag = 1'b0;
    reset_cycle   = 1'b1;
    model_reset();
    #2;
    check("rst_pc",     32'(bus.pc),       32'h00);
    check("rst_opcode", 32'(bus.opcode),   32'h00);
    check("rst_halted", 32'(bus.halted),   32'h0);
    check("rst_mar",    32'(bus.mem_addr), 32'h00);

    // Reset held across an edge that presents STATE_HALT: reset wins
    step(STATE_HALT, 8'h00, 1'b0);
    check("rst_vs_halt", 32'(bus.halted), 32'h0);
    reset_cycle = 1'b0;

    step(STATE_FETCH_PC, 8'h00, 1'b0);
    check("first_fetch_mar", 32'(bus.mem_addr), 32'h00);
    check("first_fetch_pc",  32'(bus.pc),       32'h01);

    for (int i = 0; i < 4; i++) step(STATE_FETCH_PC, 8'h00, 1'b0);
    check("pc_is_5", 32'(bus.pc), 32'h05);

    // Instruction latch
    step(STATE_FETCH_PC, 8'h00, 1'b0);
    step(STATE_FETCH_INST, 8'h3C, 1'b0);
    check("latch_mar",    32'(bus.mem_addr), 32'h05);
    check("latch_pc",     32'(bus.pc),       32'h06);
    check("latch_opcode", 32'(bus.opcode),   32'h3C);

    // Two-byte immediate leaves pc at start+2
    step(STATE_FETCH_PC, 8'h00, 1'b0);
    step(STATE_LDI, 8'h77, 1'b0);
    check("ldi_operand", 32'(bus.operand), 32'h77);
    check("ldi_pc",      32'(bus.pc),      32'h07);

    step(STATE_LOAD_ADDR, 8'h9A, 1'b0);
    check("load_addr_mar", 32'(bus.mem_addr), 32'h9A);

    // Conditional jumps
    step(STATE_FETCH_INST, 8'h24, 1'b0);
    step(STATE_JUMP, 8'h40, 1'b1);
    check("jez_taken", 32'(bus.pc), 32'h40);
    step(STATE_FETCH_INST, 8'h27, 1'b0);
    step(STATE_JUMP, 8'h55, 1'b0);
    check("jez_not_taken", 32'(bus.pc),      32'h40);
    check("jez_operand",   32'(bus.operand), 32'h55);
    step(STATE_FETCH_INST, 8'h2B, 1'b0);
    step(STATE_JUMP, 8'h80, 1'b0);
    check("jnz_taken", 32'(bus.pc), 32'h80);
    step(STATE_JUMP, 8'h90, 1'b1);
    check("jnz_not_taken", 32'(bus.pc), 32'h80);
    step(STATE_FETCH_INST, 8'h3C, 1'b0);
    step(STATE_JUMP, 8'h12, 1'b1);
    check("nonjump_in_jump", 32'(bus.pc), 32'h80);
    step(STATE_FETCH_INST, 8'h21, 1'b0);
    step(STATE_JUMP, 8'hF0, 1'b1);
    check("jmp_taken", 32'(bus.pc), 32'hF0);

    // Hold states and an undefined code
    step(STATE_ALU_OP, 8'hAA, 1'b1);
    step(STATE_OUT_A, 8'hAA, 1'b1);
    step(STATE_MOV_LOAD, 8'hAA, 1'b1);
    step(4'hF, 8'hAA, 1'b1);
    check("hold_pc",      32'(bus.pc),      32'hF0);
    check("hold_operand", 32'(bus.operand), 32'hF0);

    // PC wrap
    step(STATE_FETCH_INST, 8'h20, 1'b0);
    step(STATE_JUMP, 8'hFF, 1'b0);
    step(STATE_FETCH_PC, 8'h00, 1'b0);
    check("wrap_mar", 32'(bus.mem_addr), 32'hFF);
    check("wrap_pc",  32'(bus.pc),       32'h00);

    // Three separated retirements
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(STATE_NEXT, 8'h00, 1'b0);
      step(STATE_FETCH_PC, 8'h00, 1'b0);
    end
    step(STATE_ALU_OP, 8'h00, 1'b0);
    check("done_pulses", 32'(pulses), 32'd3);
`ifdef CPU_FETCH_RETIRE_COUNT_EN
    check("retired_3", 32'(bus.retired), 32'd3);
`endif

    // Halt freezes everything
    step(STATE_HALT, 8'h00, 1'b0);
    check("halted_set", 32'(bus.halted), 32'h1);
    step(STATE_FETCH_PC, 8'h00, 1'b0);
    step(STATE_JUMP, 8'h11, 1'b0);
    step(STATE_FETCH_INST, 8'h99, 1'b0);
    step(STATE_NEXT, 8'h00, 1'b0);
    step(STATE_ALU_OP, 8'h00, 1'b0);
    check("halt_pc",     32'(bus.pc),     32'h03);
    check("halt_opcode", 32'(bus.opcode), 32'h20);
    check("halt_no_done", 32'(pulses), 32'd3);

    // Asynchronous reset mid-cycle
    reset_cycle = 1'b1;
    model_reset();
    #2;
    check("async_rst_halted", 32'(bus.halted), 32'h0);
    check("async_rst_pc",     32'(bus.pc),     32'h00);
`ifdef CPU_FETCH_RETIRE_COUNT_EN
    check("async_rst_retired", 32'(bus.retired), 32'd0);
`endif
    #1;
    reset_cycle = 1'b0;
    step(STATE_FETCH_PC, 8'h00, 1'b0);
    check("post_rst_pc", 32'(bus.pc), 32'h01);
    step(STATE_ALU_OP, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
